parking_fsm: RTL and testbench
==============================

Name: parking_fsm

Overview:
Four-slot parking-lot controller. It tracks which slots are occupied, admits arriving cars into the lowest-numbered free slot, and releases slots on exit. It pulses the gate (door) on each accepted event and drives a lot-full indicator. It sits between the gate/slot sensors and the display/gate actuator logic; the status outputs are sampled once per clock by the surrounding system.

Parameters:
None. The slot count is fixed at 4.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (sampled on the rising edge of clk)
entry_sensor  input  1  car requesting entry this cycle (level, sampled each clock)
exit_sensor  input  1  car leaving this cycle (level, sampled each clock)
exit_location  input  2  index (0..3) of the slot being vacated; qualified by exit_sensor
door_open  output  1  registered; 1 for the cycle after an accepted entry or exit
full_light  output  1  1 when all 4 slots are occupied
occupancy  output  4  number of occupied slots, 0..4 (popcount of current_state)
current_state  output  4  slot bitmap; bit i = 1 means slot i is occupied
best_slot  output  2  index of the lowest-numbered free slot; 0 when the lot is full

Behaviour:
- Reset: if reset==0 at a rising clk edge, then current_state=0000 and door_open=0. This gives occupancy=0, full_light=0, best_slot=0. Reset has priority over all inputs, including mid-operation.
- State is the 4-bit occupancy map. The block counts no cars beyond the map.
- Inputs are level-sampled every clock. Each cycle with entry_sensor=1 is a new arrival; no edge detection.
- Per clock, with S = the current map:
  - Exit step: if exit_sensor=1 and S[exit_location]=1, clear that bit and mark the exit as accepted. If the slot is already free, the exit is ignored.
  - Entry step: if entry_sensor=1 and the map after the exit step has a free slot, set its lowest-index zero bit and mark the entry as accepted. If no slot is free, the car is refused and the map is unchanged.
  - Simultaneous entry and exit: the exit is applied first, so a car arriving at a full lot enters the slot just vacated in that same cycle.
  - door_open (next) = accepted entry OR accepted exit; otherwise 0. It is a one-cycle pulse per accepting cycle; consecutive accepting cycles hold it at 1.
- Combinational outputs derived from the registered map:
  - full_light = (current_state==4'b1111).
  - occupancy = popcount(current_state), zero-extended to 4 bits.
  - best_slot = lowest i with current_state[i]=0, or 2'd0 if full.
- All outputs are stable 1 cycle after the input-sampling edge (latency 1).
- No X or undefined states: every 4-bit map is legal.

Test Plan:
1. Hold reset=0 for one edge, then release (reset=1, all other inputs 0) -> current_state=0000, occupancy=0, best_slot=0, door_open=0, full_light=0.
2. Four consecutive cycles of entry_sensor=1 (exit_sensor=0) -> current_state goes 0001, 0011, 0111, 1111; best_slot goes 1, 2, 3, 0; door_open=1 each cycle; full_light=1 only after the fourth; occupancy=4.
3. Lot full, entry_sensor=1 -> state stays 1111, door_open=0, full_light=1.
4. From 1111, exit_sensor=1 with exit_location=2 -> 1011, occupancy=3, best_slot=2, door_open=1, full_light=0. A following entry -> 1111, door_open=1.
5. From 0001, exit_sensor=1 with exit_location=3 (slot already free) -> state unchanged at 0001, door_open=0. Then entry=1 and exit=1 with exit_location=0 in the same cycle -> 0001 (slot 0 freed and refilled), door_open=1.
6. From 0111, assert reset=0 for one edge -> 0000, door_open=0, full_light=0, best_slot=0.

Source files
------------

// File: rtl/parking_fsm.sv
// parking_fsm: four-slot parking-lot controller.
// Tracks slot occupancy as a 4-bit map, admits arrivals into the lowest free
// slot, and releases slots on exit. Exits are applied before entries in the
// same cycle, so an arrival at a full lot can take the slot just vacated.
// door_open pulses for one cycle after every cycle that accepted an event.
//
// Handshake: there is none. entry_sensor and exit_sensor are plain levels
// sampled on every rising edge. Each high cycle is one independent event.
// A refused entry, or an exit from a slot that is already free, is dropped
// without any back-pressure.
module parking_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] exit_location,
    output logic       door_open,
    output logic       full_light,
    output logic [3:0] occupancy,
    output logic [3:0] current_state,
    output logic [1:0] best_slot
);

    logic [3:0] r_state;
    logic       r_door;

    logic [3:0] w_after_exit;
    logic [3:0] w_next_state;
    logic       w_exit_ok;
    logic       w_has_free;
    logic [1:0] w_free_idx;
    logic       w_entry_ok;
    logic       w_next_door;
    logic [1:0] w_best;

    // State register: the occupancy map plus the registered door pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= 4'b0000;
            r_door  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_door  <= w_next_door;
        end
    end

    // Next-state logic: apply the exit first, then fill the lowest free slot.
    always_comb begin
        w_after_exit = r_state;
        w_exit_ok    = exit_sensor && r_state[exit_location];
        if (w_exit_ok) begin
            w_after_exit[exit_location] = 1'b0;
        end

        // Scan from the top down so the lowest free index wins.
        w_has_free = 1'b0;
        w_free_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!w_after_exit[i]) begin
                w_has_free = 1'b1;
                w_free_idx = 2'(i);
            end
        end

        w_entry_ok   = entry_sensor && w_has_free;
        w_next_state = w_after_exit;
        if (w_entry_ok) begin
            w_next_state[w_free_idx] = 1'b1;
        end
        w_next_door = w_entry_ok || w_exit_ok;
    end

    // Output logic: status derived from the registered map only.
    always_comb begin
        w_best = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_state[i]) begin
                w_best = 2'(i);
            end
        end

        current_state = r_state;
        door_open     = r_door;
        full_light    = (r_state == 4'b1111);
        occupancy     = 4'(r_state[0]) + 4'(r_state[1])
                      + 4'(r_state[2]) + 4'(r_state[3]);
        best_slot     = w_best;
    end

endmodule

// File: tb/tb_parking_fsm.sv
// tb_parking_fsm: directed steps followed by random traffic for parking_fsm.
// The reference model keeps one flag per slot and recomputes every status
// output from those flags after each clock.
module tb_parking_fsm;

  logic       clk;
  logic       reset;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] exit_location;
  logic       door_open;
  logic       full_light;
  logic [3:0] occupancy;
  logic [3:0] current_state;
  logic [1:0] best_slot;

  int n_total = 0;
  int n_pass  = 0;

  // reference model
  bit slot_taken [4];
  bit exp_door;

  parking_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .entry_sensor  (entry_sensor),
    .exit_sensor   (exit_sensor),
    .exit_location (exit_location),
    .door_open     (door_open),
    .full_light    (full_light),
    .occupancy     (occupancy),
    .current_state (current_state),
    .best_slot     (best_slot)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  // Model one clock of the lot from the plain rules.
  task automatic model_step(input logic rst_n, input logic ent, input logic ex,
                            input logic [1:0] loc);
    bit accepted;
    if (!rst_n) begin
      foreach (slot_taken[i]) slot_taken[i] = 1'b0;
      exp_door = 1'b0;
    end else begin
      accepted = 1'b0;
      if (ex && slot_taken[loc]) begin
        slot_taken[loc] = 1'b0;
        accepted = 1'b1;
      end
      if (ent) begin
        for (int i = 0; i < 4; i++) begin
          if (!slot_taken[i]) begin
            slot_taken[i] = 1'b1;
            accepted = 1'b1;
            break;
          end
        end
      end
      exp_door = accepted;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] map;
    int         cars;
    int         first_free;
    map        = 4'b0000;
    cars       = 0;
    first_free = -1;
    for (int i = 0; i < 4; i++) begin
      map[i] = slot_taken[i];
      if (slot_taken[i]) cars++;
      else if (first_free < 0) first_free = i;
    end
    if (first_free < 0) first_free = 0;
    chk({tag, ".map"},  current_state, map);
    chk({tag, ".occ"},  occupancy, 4'(cars));
    chk({tag, ".full"}, {3'b0, full_light}, {3'b0, (cars == 4)});
    chk({tag, ".best"}, {2'b0, best_slot}, 4'(first_free));
    chk({tag, ".door"}, {3'b0, door_open}, {3'b0, exp_door});
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic step(input logic rst_n, input logic ent, input logic ex,
                      input logic [1:0] loc, input string tag);
    reset         = rst_n;
    entry_sensor  = ent;
    exit_sensor   = ex;
    exit_location = loc;
    @(posedge clk);
    model_step(rst_n, ent, ex, loc);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0; exit_location = 2'd0;
    foreach (slot_taken[i]) slot_taken[i] = 1'b0;
    exp_door = 1'b0;

    // reset and idle
    step(1'b0, 1'b0, 1'b0, 2'd0, "reset");
    step(1'b1, 1'b0, 1'b0, 2'd0, "idle");
    // fill the lot
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 2'd0, "fill");
    chk("fill.const_map", current_state, 4'b1111);
    // refused entry when full
    step(1'b1, 1'b1, 1'b0, 2'd0, "refuse");
    chk("refuse.const_door", {3'b0, door_open}, 4'd0);
    // exit slot 2, then refill
    step(1'b1, 1'b0, 1'b1, 2'd2, "exit2");
    chk("exit2.const_map", current_state, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 2'd0, "refill");
    // simultaneous exit and entry at a full lot
    step(1'b1, 1'b1, 1'b1, 2'd1, "swap_full");
    chk("swap_full.const_map", current_state, 4'b1111);
    // reach 0001, then exit a free slot, then swap on slot 0
    step(1'b0, 1'b0, 1'b0, 2'd0, "reset2");
    step(1'b1, 1'b1, 1'b0, 2'd0, "one");
    step(1'b1, 1'b0, 1'b1, 2'd3, "exit_free");
    chk("exit_free.const_door", {3'b0, door_open}, 4'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0, "swap0");
    chk("swap0.const_map", current_state, 4'b0001);
    // reset from 0111
    step(1'b1, 1'b1, 1'b0, 2'd0, "two");
    step(1'b1, 1'b1, 1'b0, 2'd0, "three");
    step(1'b0, 1'b1, 1'b1, 2'd0, "reset_mid");
    chk("reset_mid.const_map", current_state, 4'b0000);

    // random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 29) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
